// File: rtl/data_memory.sv
// 256 x 8 single-port data memory: combinational read gated by ReadMem,
// synchronous write, and an asynchronous reset that clears every word.
module data_memory #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ReadMem,
    input  logic         WriteMem,
    input  logic [A-1:0] DataAddress,
    input  logic [W-1:0] DataIn,
    output logic [W-1:0] DataOut
);

    localparam int DEPTH = 2 ** A;

    // Kept under this exact name so benches can preload and inspect it hierarchically.
    logic [W-1:0] mem_core [0:DEPTH-1];

    // NOTE: the whole array is cleared by the asynchronous reset, which rules out
    // mapping onto block RAM; that is accepted so the contents are known after reset.
    // Sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_core[i] <= '0;
            end
        end else if (WriteMem) begin
            // An X/Z address makes this a no-op in simulation, so no other word is touched.
            mem_core[DataAddress] <= DataIn;
        end
    end

    // Purely combinational read: backdoor writes and same-cycle writes show up immediately.
    assign DataOut = (ReadMem && !reset) ? mem_core[DataAddress] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: reset, write/read, read gating,
// backdoor access, write disable, reset priority and address boundaries.
module tb_data_memory;

    logic       clk;
    logic       reset;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] DataAddress;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    int n_cmp = 0;
    int n_err = 0;

    data_memory #(.W(8), .A(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ReadMem    (ReadMem),
        .WriteMem   (WriteMem),
        .DataAddress(DataAddress),
        .DataIn     (DataIn),
        .DataOut    (DataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One synchronous write: drive away from the edge, clock it in, release.
    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        DataAddress = addr;
        DataIn      = data;
        WriteMem    = 1'b1;
        @(posedge clk);
        #1;
        WriteMem = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] obs;
        // Still in power-on reset here.
        ReadMem     = 1'b1;
        DataAddress = 8'd3;
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dataout_por: got %h want %h", DataOut, 8'h00);
        end
        @(negedge clk);
        reset = 1'b0;
        do_write(8'd3, 8'hA5);
        obs = dut.mem_core[3];
        n_cmp++;
        if (obs !== 8'hA5) begin
            n_err++;
            $display("FAIL reset_prewrite: got %h want %h", obs, 8'hA5);
        end
        // Asynchronous pulse between edges.
        #2;
        reset = 1'b1;
        #1;
        obs = dut.mem_core[3];
        n_cmp++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async_clear: got %h want %h", obs, 8'h00);
        end
        ReadMem     = 1'b1;
        DataAddress = 8'd3;
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dataout: got %h want %h", DataOut, 8'h00);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_read;
        logic [15:0] word;
        do_write(8'h06, 8'h34);
        do_write(8'h07, 8'h12);
        ReadMem     = 1'b1;
        DataAddress = 8'h06;
        #1;
        n_cmp++;
        if (DataOut !== 8'h34) begin
            n_err++;
            $display("FAIL wr_read_6: got %h want %h", DataOut, 8'h34);
        end
        DataAddress = 8'h07;
        #1;
        n_cmp++;
        if (DataOut !== 8'h12) begin
            n_err++;
            $display("FAIL wr_read_7: got %h want %h", DataOut, 8'h12);
        end
        word = {dut.mem_core[7], dut.mem_core[6]};
        n_cmp++;
        if (word !== 16'h1234) begin
            n_err++;
            $display("FAIL wr_le16: got %h want %h", word, 16'h1234);
        end
    endtask

    task automatic test_read_gating;
        DataAddress = 8'h06;
        ReadMem     = 1'b0;
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_err++;
            $display("FAIL gate_off: got %h want %h", DataOut, 8'h00);
        end
        ReadMem = 1'b1;
        #1;
        n_cmp++;
        if (DataOut !== 8'h34) begin
            n_err++;
            $display("FAIL gate_on: got %h want %h", DataOut, 8'h34);
        end
    endtask

    task automatic test_backdoor;
        @(negedge clk);
        dut.mem_core[4] = 8'h00;
        dut.mem_core[5] = 8'h3C;
        ReadMem     = 1'b1;
        DataAddress = 8'd4;
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_err++;
            $display("FAIL backdoor_4: got %h want %h", DataOut, 8'h00);
        end
        DataAddress = 8'd5;
        #1;
        n_cmp++;
        if (DataOut !== 8'h3C) begin
            n_err++;
            $display("FAIL backdoor_5: got %h want %h", DataOut, 8'h3C);
        end
    endtask

    task automatic test_read_during_write;
        @(negedge clk);
        ReadMem     = 1'b1;
        DataAddress = 8'd20;
        DataIn      = 8'h9B;
        WriteMem    = 1'b1;
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_err++;
            $display("FAIL rw_before_edge: got %h want %h", DataOut, 8'h00);
        end
        @(posedge clk);
        #1;
        WriteMem = 1'b0;
        n_cmp++;
        if (DataOut !== 8'h9B) begin
            n_err++;
            $display("FAIL rw_after_edge: got %h want %h", DataOut, 8'h9B);
        end
    endtask

    task automatic test_write_disable;
        @(negedge clk);
        DataAddress = 8'd10;
        DataIn      = 8'hFF;
        WriteMem    = 1'b0;
        ReadMem     = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_err++;
            $display("FAIL wdis_addr10: got %h want %h", DataOut, 8'h00);
        end
    endtask

    task automatic test_reset_priority;
        logic [7:0] obs;
        @(negedge clk);
        reset       = 1'b1;
        DataAddress = 8'd11;
        DataIn      = 8'h77;
        WriteMem    = 1'b1;
        @(posedge clk);
        #1;
        obs = dut.mem_core[11];
        n_cmp++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL rstpri_write: got %h want %h", obs, 8'h00);
        end
        // Earlier contents must also have been cleared by this reset.
        obs = dut.mem_core[6];
        n_cmp++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL rstpri_clear6: got %h want %h", obs, 8'h00);
        end
        @(negedge clk);
        WriteMem = 1'b0;
        reset    = 1'b0;
        ReadMem  = 1'b1;
        #1;
        n_cmp++;
        if (DataOut !== 8'h00) begin
            n_err++;
            $display("FAIL rstpri_read11: got %h want %h", DataOut, 8'h00);
        end
    endtask

    task automatic test_boundaries;
        logic [7:0] addrs [4];
        logic [7:0] exps  [4];
        addrs = '{8'd0, 8'd255, 8'd1, 8'd254};
        exps  = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        do_write(8'd0,   8'h5A);
        do_write(8'd255, 8'hC3);
        ReadMem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DataAddress = addrs[i];
            #1;
            n_cmp++;
            if (DataOut !== exps[i]) begin
                n_err++;
                $display("FAIL boundary_addr%0d: got %h want %h", addrs[i], DataOut, exps[i]);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataAddress = '0;
        DataIn      = '0;
        @(posedge clk);
        test_reset();
        test_write_read();
        test_read_gating();
        test_backdoor();
        test_read_during_write();
        test_write_disable();
        test_reset_priority();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
